// File: rtl/fpu_div_sched_pkg.sv
// Shared types for the pipelined FP divider scheduler: slot states, issue tags
// and the one-hot to requester-ID encoder.
package fpu_div_sched_pkg;

  localparam int FP_WIDTH = 32;
  localparam int ID_W     = 3;
  localparam int MAX_REQ  = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_BUSY = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: '0};

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [MAX_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/fpu_div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps,
// so the most recently granted requester has lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // NOTE: every variable written here gets a value before any condition,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_div_scheduler.sv
// Shares one pipelined FP divider among NUM_REQ requesters with per-requester
// result holding. Define FPU_DIV_SCHED_PERF_EN to add issue/conflict counters.
module fpu_div_scheduler
  import fpu_div_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [FP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [FP_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        div_in_valid,
  output logic [FP_WIDTH-1:0]         div_a,
  output logic [FP_WIDTH-1:0]         div_b,
  input  logic [FP_WIDTH-1:0]         div_result,
  input  logic                        div_dbz,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [FP_WIDTH*NUM_REQ-1:0] rsp_data,
  output logic [NUM_REQ-1:0]          rsp_dbz,
  input  logic [NUM_REQ-1:0]          rsp_ready
`ifdef FPU_DIV_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_issued,
  output logic [31:0]                 perf_conflict
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic                handshake;
  logic [ID_W-1:0]     gnt_id;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [FP_WIDTH-1:0] sel_a, sel_b;

  tag_t                issue_tag_q, issue_tag_d;
  logic [FP_WIDTH-1:0] div_a_q, div_a_d;
  logic [FP_WIDTH-1:0] div_b_q, div_b_d;
  tag_t                tag_q [LATENCY];
  tag_t                exit_tag;

  slot_state_e         slot_q [NUM_REQ];
  slot_state_e         slot_d [NUM_REQ];
  logic [FP_WIDTH-1:0] hold_data_q [NUM_REQ];
  logic [NUM_REQ-1:0]  hold_dbz_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant)
  );

  // The grant is combinational, so it is forced low while reset is held.
  assign req_ready = reset_n ? grant : '0;
  assign handshake = |req_ready;
  assign gnt_id    = onehot_to_id(MAX_REQ'(req_ready));

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a    = req_a[i*FP_WIDTH +: FP_WIDTH];
        sel_b    = req_b[i*FP_WIDTH +: FP_WIDTH];
        rr_ptr_d = PTR_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register: operands and the tag that travels alongside them
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_tag_d = TAG_NONE;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    if (handshake) begin
      issue_tag_d = '{valid: 1'b1, id: gnt_id};
      div_a_d     = sel_a;
      div_b_d     = sel_b;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
      issue_tag_q <= TAG_NONE;
      div_a_q     <= '0;
      div_b_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_tag_q <= issue_tag_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
    end
  end

  assign div_in_valid = issue_tag_q.valid;
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;

  // ---------------------------------------------------------------------------
  // Tag pipeline: issue register plus LATENCY stages lines the exiting tag up
  // with the divider output for that operation.
  // ---------------------------------------------------------------------------
  // NOTE: register arrays are normally left unreset, but these stages carry
  // the valid bits, so clearing them is what discards in-flight operations.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LATENCY; k++) tag_q[k] <= TAG_NONE;
    end else begin
      tag_q[0] <= issue_tag_q;
      for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign exit_tag = tag_q[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Per-requester slot FSMs and result holding registers
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_IDLE: if (req_ready[i]) slot_d[i] = SLOT_BUSY;
        SLOT_BUSY: if (exit_tag.valid && exit_tag.id == ID_W'(i)) slot_d[i] = SLOT_DONE;
        SLOT_DONE: if (rsp_ready[i]) slot_d[i] = SLOT_IDLE;
        default:   slot_d[i] = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i]      <= SLOT_IDLE;
        hold_data_q[i] <= '0;
      end
      hold_dbz_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        if (exit_tag.valid && exit_tag.id == ID_W'(i)) begin
          hold_data_q[i] <= div_result;
          hold_dbz_q[i]  <= div_dbz;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i]                      = (slot_q[i] == SLOT_DONE);
      rsp_data[i*FP_WIDTH +: FP_WIDTH] = hold_data_q[i];
    end
  end

  assign rsp_dbz = hold_dbz_q;

`ifdef FPU_DIV_SCHED_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_issued_q, perf_conflict_q;
  logic [3:0]  n_eligible;

  always_comb begin
    n_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) n_eligible = n_eligible + 4'(eligible[i]);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (handshake)        perf_issued_q   <= perf_issued_q + 32'd1;
      if (n_eligible >= 2)  perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_issued   = perf_issued_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_fpu_div_scheduler.sv
// Directed bench for fpu_div_scheduler with a LATENCY-deep divider model.
module tb_fpu_div_scheduler;

  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic            clk_in;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [32*NR-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready;
  logic            div_in_valid;
  logic [31:0]     div_a, div_b;
  logic [31:0]     div_result;
  logic            div_dbz;
  logic [NR-1:0]   rsp_valid;
  logic [32*NR-1:0] rsp_data;
  logic [NR-1:0]   rsp_dbz;
  logic [NR-1:0]   rsp_ready;
`ifdef FPU_DIV_SCHED_PERF_EN
  logic [31:0]     perf_issued, perf_conflict;
`endif

  int errors = 0;
  int checks = 0;

  fpu_div_scheduler #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .div_in_valid (div_in_valid),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_result   (div_result),
    .div_dbz      (div_dbz),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_dbz      (rsp_dbz),
    .rsp_ready    (rsp_ready)
`ifdef FPU_DIV_SCHED_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_conflict (perf_conflict)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Divider model: quotient is a when b == 1.0, otherwise a^b; dbz when b is +/-0.
  logic [LAT-1:0] mv;
  logic [31:0]    ma [LAT];
  logic [31:0]    mb [LAT];

  initial begin
    mv = '0;
    for (int i = 0; i < LAT; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  end

  always @(posedge clk_in) begin
    mv[0] <= div_in_valid;
    ma[0] <= div_a;
    mb[0] <= div_b;
    for (int i = 1; i < LAT; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
      mb[i] <= mb[i-1];
    end
  end

  always_comb begin
    div_result = (mb[LAT-1] == ONE) ? ma[LAT-1] : (ma[LAT-1] ^ mb[LAT-1]);
    div_dbz    = mv[LAT-1] && (mb[LAT-1][30:0] == 31'd0);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] rdat(input int i);
    return rsp_data[32*i +: 32];
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = '0;
    tick; tick;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (div_in_valid !== 1'b0) begin errors++; $display("FAIL rst_div_in_valid: got %b want 0", div_in_valid); end
    checks++; if ({div_a, div_b} !== 64'd0) begin errors++; $display("FAIL rst_div_ops: got %h %h want 0", div_a, div_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_dbz !== 4'b0000) begin errors++; $display("FAIL rst_rsp: got v=%b dbz=%b want 0", rsp_valid, rsp_dbz); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    req_valid = '0;
    reset_n   = 1'b1;
    tick;
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_single;
    req_a[64 +: 32] = 32'h4040_0000;
    req_b[64 +: 32] = ONE;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    tick;  // cycle 1: handshake happened, requester keeps asking
    checks++; if (div_in_valid !== 1'b1 || div_a !== 32'h4040_0000 || div_b !== ONE) begin
      errors++; $display("FAIL single_issue: got v=%b a=%h b=%h want 1 40400000 3f800000", div_in_valid, div_a, div_b); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_busy_nogrant: got %b want 0000", req_ready); end
    tick;  // cycle 2
    checks++; if (div_in_valid !== 1'b0) begin errors++; $display("FAIL single_issue_drop: got %b want 0", div_in_valid); end
    for (int c = 2; c < 5; c++) begin
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp c%0d: got %b want 0000", c, rsp_valid); end
      tick;
    end
    for (int c = 5; c < 8; c++) begin
      checks++; if (rsp_valid !== 4'b0100 || rdat(2) !== 32'h4040_0000 || rsp_dbz !== 4'b0000) begin
        errors++; $display("FAIL single_rsp c%0d: got v=%b d=%h dbz=%b want 0100 40400000 0000", c, rsp_valid, rdat(2), rsp_dbz); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_done_nogrant c%0d: got %b want 0000", c, req_ready); end
      tick;
    end
    rsp_ready = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0100) begin
      errors++; $display("FAIL single_no_same_cycle: got rdy=%b v=%b want 0000 0100", req_ready, rsp_valid); end
    tick;
    rsp_ready = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_reeligible: got v=%b rdy=%b want 0000 0100", rsp_valid, req_ready); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_dbz;
    req_a[96 +: 32] = ONE;
    req_b[96 +: 32] = 32'h0000_0000;
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL dbz_grant: got %b want 1000", req_ready); end
    tick;
    req_valid = '0;
    repeat (4) tick;
    checks++; if (rsp_valid !== 4'b1000 || rsp_dbz !== 4'b1000 || rdat(3) !== ONE) begin
      errors++; $display("FAIL dbz_rsp: got v=%b dbz=%b d=%h want 1000 1000 3f800000", rsp_valid, rsp_dbz, rdat(3)); end
    rsp_ready = 4'b1000;
    tick;
    rsp_ready = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL dbz_consume: got %b want 0000", rsp_valid); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    int g;
    req_b = {4{ONE}};
    rsp_ready = '1;
    req_valid = '1;
    for (int k = 0; k < 18; k++) begin
      if (k % 6 == 0) for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h4000_0000 + 32'((k/6)*16 + i);
      #1;
      exp_v = (k % 6 < 4) ? 4'(1 << (k % 6)) : 4'b0000;
      checks++; if (req_ready !== exp_v) begin errors++; $display("FAIL b2b_grant k%0d: got %b want %b", k, req_ready, exp_v); end
      if (k >= 1) begin
        g = (k - 1) % 6;
        exp_d = 32'h4000_0000 + 32'(((k-1)/6)*16 + g);
        checks++; if (div_in_valid !== (g < 4)) begin errors++; $display("FAIL b2b_div_valid k%0d: got %b want %b", k, div_in_valid, g < 4); end
        if (g < 4) begin
          checks++; if (div_a !== exp_d) begin errors++; $display("FAIL b2b_div_a k%0d: got %h want %h", k, div_a, exp_d); end
        end
      end
      if (k >= 5) begin
        g = (k - 5) % 6;
        exp_v = (g < 4) ? 4'(1 << g) : 4'b0000;
        checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b_rsp_valid k%0d: got %b want %b", k, rsp_valid, exp_v); end
        if (g < 4) begin
          exp_d = 32'h4000_0000 + 32'(((k-5)/6)*16 + g);
          checks++; if (rdat(g) !== exp_d) begin errors++; $display("FAIL b2b_rsp_data k%0d: got %h want %h", k, rdat(g), exp_d); end
        end
      end
      tick;
    end
    req_valid = '0;
    repeat (8) tick;
    rsp_ready = '0;
  endtask

  task automatic test_hold;
    logic [3:0] exp_g;
    int r;
    for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h4100_0000 + 32'(i);
    req_a[32 +: 32] = 32'h4120_0000;
    req_b = {4{ONE}};
    rsp_ready = 4'b1101;
    req_valid = '1;
    for (int k = 0; k < 24; k++) begin
      if (k == 2) req_a[32 +: 32] = 32'hDEAD_BEEF;
      #1;
      r = k % 6;
      if (k < 4)       exp_g = 4'(1 << k);
      else if (r == 0) exp_g = 4'b0001;
      else if (r == 2) exp_g = 4'b0100;
      else if (r == 3) exp_g = 4'b1000;
      else             exp_g = 4'b0000;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL hold_grant k%0d: got %b want %b", k, req_ready, exp_g); end
      if (k >= 6) begin
        checks++; if (rsp_valid[1] !== 1'b1 || rdat(1) !== 32'h4120_0000) begin
          errors++; $display("FAIL hold_rsp1 k%0d: got v=%b d=%h want 1 41200000", k, rsp_valid[1], rdat(1)); end
      end else if (k >= 2) begin
        checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL hold_rsp1_early k%0d: got %b want 0", k, rsp_valid[1]); end
      end
      tick;
    end
    req_valid = '0;
    rsp_ready = '1;
    tick;
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", rsp_valid[1]); end
    repeat (8) tick;
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h4200_0000 + 32'(i);
    req_b = {4{ONE}};
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << k)) begin errors++; $display("FAIL midrst_grant k%0d: got %b want %b", k, req_ready, 4'(1 << k)); end
      tick;
    end
    req_valid = '0;
    reset_n   = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000 || div_in_valid !== 1'b0 || div_a !== 32'd0 || div_b !== 32'd0) begin
      errors++; $display("FAIL midrst_issue: got rdy=%b v=%b a=%h b=%h want 0", req_ready, div_in_valid, div_a, div_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_dbz !== 4'b0000 || rsp_data !== '0) begin
      errors++; $display("FAIL midrst_rsp: got v=%b dbz=%b d=%h want 0", rsp_valid, rsp_dbz, rsp_data); end
    tick;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_stale k%0d: got %b want 0000", k, rsp_valid); end
      tick;
    end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    tick;
  endtask

`ifdef FPU_DIV_SCHED_PERF_EN
  task automatic test_perf;
    reset_n = 1'b0;
    #1;
    checks++; if (perf_issued !== 32'd0 || perf_conflict !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_issued, perf_conflict); end
    tick;
    reset_n = 1'b1;
    req_b = {4{ONE}};
    rsp_ready = '1;
    req_valid = '1;
    repeat (100) tick;
    req_valid = '0;
    #1;
    // 16 full six-cycle rounds plus 4 grants; only the opening round has >=2 eligible
    checks++; if (perf_issued !== 32'd68) begin errors++; $display("FAIL perf_issued: got %0d want 68", perf_issued); end
    checks++; if (perf_conflict !== 32'd3) begin errors++; $display("FAIL perf_conflict: got %0d want 3", perf_conflict); end
    repeat (8) tick;
    rsp_ready = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_dbz;
    test_back_to_back;
    test_hold;
    test_reset_mid;
`ifdef FPU_DIV_SCHED_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
